// File: rtl/axi_fifo_mcast_arbiter.sv
// Multicast arbiter: captures one packet word and issues it once per destination queue
// set in its bitmap, skipping full queues, with fixed or round-robin queue ordering.
module axi_fifo_mcast_arbiter #(
    parameter int unsigned DATA_WIDTH = 202,
    parameter int unsigned NUM_QUEUES = 5,
    parameter int unsigned QID_WIDTH  = 3,
    parameter int unsigned RR_MODE    = 1
) (
    input  logic                  memclk,
    input  logic                  reset_n,
    input  logic [NUM_QUEUES-1:0] oq,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  next_pkg_en,
    input  logic [NUM_QUEUES-1:0] queue_full,
    input  logic                  dout_ready,
    output logic                  dout_valid,
    output logic [QID_WIDTH-1:0]  queue_id,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [15:0]           drop_count
);

    localparam int unsigned NQ = NUM_QUEUES;
    localparam int unsigned QW = QID_WIDTH;
    localparam int unsigned SW = QID_WIDTH + 1;
    localparam int unsigned DW = DATA_WIDTH;

    generate
        if (NUM_QUEUES > (1 << QID_WIDTH)) begin : g_qid_check
            $error("axi_fifo_mcast_arbiter: NUM_QUEUES does not fit in QID_WIDTH");
        end
    endgenerate

    logic [NQ-1:0]   pending, pending_n;
    logic [QW-1:0]   ptr, ptr_n;
    logic            dout_valid_n;
    logic [QW-1:0]   queue_id_n;
    logic [DW-1:0]   dout_n;
    logic [15:0]     drop_count_n;
    logic            next_pkg_en_n;
    logic            capture, handshake, load, found;
    logic [NQ-1:0]   mask, rot, served;
    logic [2*NQ-1:0] dbl;
    logic [QW-1:0]   start, off, sel;
    logic [SW-1:0]   sum;

    // Next-state: capture / handshake / retry decide whether a new selection is loaded
    always_comb begin
        pending_n    = pending;
        ptr_n        = ptr;
        dout_valid_n = dout_valid;
        queue_id_n   = queue_id;
        dout_n       = dout;
        drop_count_n = drop_count;
        load         = 1'b0;
        capture      = din_valid && next_pkg_en;
        handshake    = dout_valid && dout_ready;
        served       = NQ'(1) << queue_id;

        if (capture) begin
            if (oq == '0) begin
                if (drop_count != 16'hFFFF) drop_count_n = drop_count + 16'd1;
            end else begin
                pending_n = oq;
                dout_n    = din;
                load      = 1'b1;
            end
        end else if (handshake) begin
            pending_n = pending & ~served;
            if (RR_MODE != 0) begin
                ptr_n = (queue_id == QW'(NQ - 1)) ? '0 : queue_id + QW'(1);
            end
            load = 1'b1;
        end else if (pending != '0 && !dout_valid) begin
            load = 1'b1;
        end

        // Rotate the eligible mask so the search always starts at bit 0
        start = (RR_MODE != 0) ? ptr_n : '0;
        mask  = pending_n & ~queue_full;
        dbl   = {mask, mask};
        rot   = NQ'(dbl >> start);
        found = 1'b0;
        off   = '0;
        for (int i = int'(NQ) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = QW'(i);
            end
        end
        sum = SW'(start) + SW'(off);
        if (sum >= SW'(NQ)) sum = sum - SW'(NQ);
        sel = QW'(sum);

        if (load) begin
            dout_valid_n = found;
            if (found) queue_id_n = sel;
        end
        next_pkg_en_n = (pending_n == '0);
    end

    always_ff @(posedge memclk or negedge reset_n) begin
        if (!reset_n) begin
            pending     <= '0;
            ptr         <= '0;
            dout_valid  <= 1'b0;
            queue_id    <= '0;
            dout        <= '0;
            drop_count  <= '0;
            next_pkg_en <= 1'b0;
        end else begin
            pending     <= pending_n;
            ptr         <= ptr_n;
            dout_valid  <= dout_valid_n;
            queue_id    <= queue_id_n;
            dout        <= dout_n;
            drop_count  <= drop_count_n;
            next_pkg_en <= next_pkg_en_n;
        end
    end

endmodule

// File: tb/tb_axi_fifo_mcast_arbiter.sv
// Directed bench for axi_fifo_mcast_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_axi_fifo_mcast_arbiter;

    logic         memclk = 1'b0;
    logic         reset_n;
    logic [4:0]   oq;
    logic         din_valid;
    logic [201:0] din;
    logic [4:0]   queue_full;
    logic         dout_ready;

    logic         next_pkg_en, dout_valid;
    logic [2:0]   queue_id;
    logic [201:0] dout;
    logic [15:0]  drop_count;

    logic         f_next_pkg_en, f_dout_valid;
    logic [2:0]   f_queue_id;
    logic [201:0] f_dout;
    logic [15:0]  f_drop_count;

    int total = 0;
    int bad   = 0;

    always #5 memclk = ~memclk;

    axi_fifo_mcast_arbiter #(.DATA_WIDTH(202), .NUM_QUEUES(5), .QID_WIDTH(3), .RR_MODE(1)) dut (
        .memclk(memclk), .reset_n(reset_n), .oq(oq), .din_valid(din_valid), .din(din),
        .next_pkg_en(next_pkg_en), .queue_full(queue_full), .dout_ready(dout_ready),
        .dout_valid(dout_valid), .queue_id(queue_id), .dout(dout), .drop_count(drop_count)
    );

    axi_fifo_mcast_arbiter #(.DATA_WIDTH(202), .NUM_QUEUES(5), .QID_WIDTH(3), .RR_MODE(0)) dut_fix (
        .memclk(memclk), .reset_n(reset_n), .oq(oq), .din_valid(din_valid), .din(din),
        .next_pkg_en(f_next_pkg_en), .queue_full(queue_full), .dout_ready(dout_ready),
        .dout_valid(f_dout_valid), .queue_id(f_queue_id), .dout(f_dout), .drop_count(f_drop_count)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge memclk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] q, input logic [201:0] d);
        chk({tag, "_valid"}, 256'(dout_valid), 256'(v));
        if (v) begin
            chk({tag, "_qid"}, 256'(queue_id), 256'(q));
            chk({tag, "_dout"}, 256'(dout), 256'(d));
        end
    endtask

    initial begin
        reset_n = 1'b0; oq = '0; din_valid = 1'b0; din = '0; queue_full = '0; dout_ready = 1'b0;
        step();
        step();
        chk("rst_next_pkg_en", 256'(next_pkg_en), 256'(0));
        chk("rst_dout_valid", 256'(dout_valid), 256'(0));
        chk("rst_queue_id", 256'(queue_id), 256'(0));
        chk("rst_dout", 256'(dout), 256'(0));
        chk("rst_drop_count", 256'(drop_count), 256'(0));
        #1 reset_n = 1'b1;
        step();
        chk("arm_next_pkg_en", 256'(next_pkg_en), 256'(1));

        // Three destinations, one per cycle, starting from ptr 0
        din = 202'd1; oq = 5'b01011; din_valid = 1'b1; dout_ready = 1'b1;
        step();
        din_valid = 1'b0;
        chk_out("w1_a", 1'b1, 3'd0, 202'd1);
        chk("w1_a_busy", 256'(next_pkg_en), 256'(0));
        chk("w1_a_fix_qid", 256'(f_queue_id), 256'(0));
        step();
        chk_out("w1_b", 1'b1, 3'd1, 202'd1);
        step();
        chk_out("w1_c", 1'b1, 3'd3, 202'd1);
        step();
        chk("w1_done_valid", 256'(dout_valid), 256'(0));
        chk("w1_done_next_pkg_en", 256'(next_pkg_en), 256'(1));
        chk("w1_ptr", 256'(dut.ptr), 256'(4));

        // Round-robin from ptr 4 versus fixed lowest-first
        din = 202'd101; oq = 5'b11001; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk_out("w2_a", 1'b1, 3'd4, 202'd101);
        chk("w2_a_fix_qid", 256'(f_queue_id), 256'(0));
        step();
        chk_out("w2_b", 1'b1, 3'd0, 202'd101);
        chk("w2_b_fix_qid", 256'(f_queue_id), 256'(3));
        step();
        chk_out("w2_c", 1'b1, 3'd3, 202'd101);
        chk("w2_c_fix_qid", 256'(f_queue_id), 256'(4));
        chk("w2_c_fix_valid", 256'(f_dout_valid), 256'(1));
        step();
        chk("w2_done_valid", 256'(dout_valid), 256'(0));
        chk("w2_done_fix_valid", 256'(f_dout_valid), 256'(0));
        chk("w2_done_next_pkg_en", 256'(next_pkg_en), 256'(1));

        // Backpressure hold while queue_full toggles
        din = 202'd7; oq = 5'b00110; din_valid = 1'b1; dout_ready = 1'b0;
        step();
        din_valid = 1'b0;
        chk_out("hold_0", 1'b1, 3'd1, 202'd7);
        queue_full = 5'b00010;
        step();
        chk_out("hold_1", 1'b1, 3'd1, 202'd7);
        queue_full = 5'b00110;
        step();
        chk_out("hold_2", 1'b1, 3'd1, 202'd7);
        queue_full = 5'b00000;
        step();
        chk_out("hold_3", 1'b1, 3'd1, 202'd7);
        dout_ready = 1'b1;
        step();
        chk_out("hold_release", 1'b1, 3'd2, 202'd7);
        step();
        chk("hold_done_valid", 256'(dout_valid), 256'(0));
        chk("hold_done_next_pkg_en", 256'(next_pkg_en), 256'(1));

        // Reset to ptr 0, then full-queue skip and retry
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        step();
        chk("rr0_next_pkg_en", 256'(next_pkg_en), 256'(1));
        din = 202'd9; oq = 5'b00011; queue_full = 5'b00001; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk_out("full_a", 1'b1, 3'd1, 202'd9);
        step();
        chk("full_stall_valid", 256'(dout_valid), 256'(0));
        chk("full_stall_next_pkg_en", 256'(next_pkg_en), 256'(0));
        step();
        chk("full_stall2_valid", 256'(dout_valid), 256'(0));
        queue_full = 5'b00000;
        step();
        chk_out("full_retry", 1'b1, 3'd0, 202'd9);
        step();
        chk("full_done_valid", 256'(dout_valid), 256'(0));
        chk("full_done_next_pkg_en", 256'(next_pkg_en), 256'(1));

        // Empty bitmap drops, saturating at 16'hFFFF
        oq = 5'b00000; din = 202'd33; din_valid = 1'b1;
        step();
        chk("drop1_count", 256'(drop_count), 256'(1));
        chk("drop1_valid", 256'(dout_valid), 256'(0));
        chk("drop1_next_pkg_en", 256'(next_pkg_en), 256'(1));
        repeat (65535) step();
        chk("drop_sat", 256'(drop_count), 256'(16'hFFFF));
        step();
        chk("drop_sat_hold", 256'(drop_count), 256'(16'hFFFF));
        chk("drop_sat_fix", 256'(f_drop_count), 256'(16'hFFFF));
        din_valid = 1'b0;

        // Reset after the first of three handshakes
        din = 202'd5; oq = 5'b00111; din_valid = 1'b1; dout_ready = 1'b1;
        step();
        din_valid = 1'b0;
        chk_out("mid_a", 1'b1, 3'd1, 202'd5);
        step();
        chk_out("mid_b", 1'b1, 3'd2, 202'd5);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 256'(dout_valid), 256'(0));
        chk("mid_rst_qid", 256'(queue_id), 256'(0));
        chk("mid_rst_dout", 256'(dout), 256'(0));
        chk("mid_rst_next_pkg_en", 256'(next_pkg_en), 256'(0));
        chk("mid_rst_drop", 256'(drop_count), 256'(0));
        step();
        #1 reset_n = 1'b1;
        step();
        chk("mid_rel_next_pkg_en", 256'(next_pkg_en), 256'(1));
        chk("mid_rel_valid", 256'(dout_valid), 256'(0));
        step();
        chk("mid_rel_valid2", 256'(dout_valid), 256'(0));
        chk("mid_rel_drop", 256'(drop_count), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_fifo_mcast_arbiter.md
AXI_FIFO_MCAST_ARBITER -- requirements
Module: axi_fifo_mcast_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 202, width of the packet word.
REQ-002 SHALL have parameter NUM_QUEUES, default 5, number of output queues (one bit per queue in the destination bitmap).
REQ-003 SHALL have parameter QID_WIDTH, default 3, width of queue_id; an elaboration error SHALL be raised if NUM_QUEUES > 2^QID_WIDTH.
REQ-004 SHALL have parameter RR_MODE, default 1; 0 = fixed lowest-index-first, 1 = round-robin start pointer.
REQ-005 memclk  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 oq  input  NUM_QUEUES  destination bitmap of the offered word.
REQ-008 din_valid  input  1  din/oq valid.
REQ-009 din  input  DATA_WIDTH  packet word.
REQ-010 next_pkg_en  output  1  ready for a new word; capture = din_valid && next_pkg_en.
REQ-011 queue_full  input  NUM_QUEUES  per-queue full flag; a full queue is not selected.
REQ-012 dout_ready  input  1  downstream accept.
REQ-013 dout_valid  output  1  registered; dout/queue_id valid.
REQ-014 queue_id  output  QID_WIDTH  registered; index of the target queue.
REQ-015 dout  output  DATA_WIDTH  registered; captured word.
REQ-016 drop_count  output  16  saturating count of words dropped for an empty bitmap.

Function
REQ-017 Internal state SHALL be the pending bitmap, data register, RR pointer ptr (0..NUM_QUEUES-1), and the output registers.
REQ-018 next_pkg_en SHALL be 1 iff pending == 0 and the block is out of reset (registered arm flag, see REQ-031).
REQ-019 On capture the block SHALL latch din into dout and set pending = oq; dout SHALL stay constant until the next capture.
REQ-020 Capture with oq == 0 SHALL drop the word: no dout_valid, drop_count += 1 (saturating at 16'hFFFF), next_pkg_en stays 1.
REQ-021 Load event = capture with oq != 0, or handshake (dout_valid && dout_ready); at load, mask M = new_pending & ~queue_full.
REQ-022 Selection: RR_MODE=1 picks the first set bit of M searching upward from ptr with wrap modulo NUM_QUEUES; RR_MODE=0 searches upward from index 0.
REQ-023 At load with M != 0: dout_valid <= 1, queue_id <= selected index; with M == 0: dout_valid <= 0.
REQ-024 On handshake the pending bit for queue_id SHALL be cleared in the same edge; in RR_MODE=1, ptr <= (queue_id + 1) mod NUM_QUEUES.
REQ-025 Latency: dout_valid SHALL assert on the edge after capture; back-to-back handshakes SHALL sustain one destination per cycle.
REQ-026 While dout_valid && !dout_ready, queue_id and dout SHALL hold regardless of queue_full changes.
REQ-027 Retry: while pending != 0 and dout_valid == 0, the block SHALL re-evaluate M every cycle and load on the first cycle M != 0.
REQ-028 When the last pending bit is cleared by handshake, dout_valid SHALL be 0 and next_pkg_en 1 on the following cycle; a new capture is not allowed in the same cycle as that handshake.
REQ-029 Each set bit of a captured oq SHALL produce exactly one handshake; no queue is served twice per word.

Reset
REQ-030 While reset_n is low: pending = 0, dout_valid = 0, queue_id = 0, dout = 0, ptr = 0, drop_count = 0, next_pkg_en = 0.
REQ-031 next_pkg_en SHALL rise on the first memclk edge after reset_n deasserts.
REQ-032 Reset mid-packet SHALL discard the remaining destinations without changing drop_count.

Verification (DATA_WIDTH=202, NUM_QUEUES=5, RR_MODE=1 unless stated)
REQ-033 Reset, then din=1, oq=5'b01011, queue_full=0, dout_ready=1 -> queue_id 0,1,3 on three consecutive cycles, dout=1; next_pkg_en=1 on the next cycle; ptr=4.
REQ-034 Next word din=101, oq=5'b11001 -> order 4,0,3; RR_MODE=0 with the same stimulus -> order 0,3,4.
REQ-035 dout_ready=0 for 3 cycles while queue_full toggles -> dout_valid, queue_id and dout held; served on the cycle dout_ready rises.
REQ-036 oq=5'b00011, queue_full=5'b00001, ptr=0 -> queue 1 served; dout_valid=0 until queue_full[0] clears, then queue 0 on the next cycle.
REQ-037 din_valid with oq=0 -> no dout_valid, drop_count=1, next_pkg_en stays 1; 65536 such words -> drop_count=16'hFFFF.
REQ-038 reset_n low after 1 of 3 handshakes -> all outputs 0 immediately; after release next_pkg_en=1 on the first edge, no stale queue_id is issued.
